udm_uart_rx: RTL and testbench
==============================

// Module: udm_uart_rx
// PURPOSE
//  UART receiver (8N1, LSB first) feeding the UDM controller's rx_done_tick_i / rx_din_bi.
//  Synchronises the asynchronous rx line and recovers bytes with oversampling and 3-sample majority vote.
//  Emits one byte strobe per good frame and flags framing errors.
//  Sits between the board RX pin and the UDM controller.
// PARAMETERS
//  CLK_FREQ_HZ  50000000  system clock frequency
//  BAUD_RATE    115200    line baud rate
//  OVERSAMPLE   16        samples per bit; even, >=8
//  (derived) DIV = CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE), integer division, must be >=2
// PORTS
//  clk_i            in   1  system clock
//  reset_i          in   1  reset, asynchronous, active-high
//  rx_i             in   1  serial line, idle high, asynchronous to clk_i
//  rx_done_tick_o   out  1  one-cycle strobe: rx_data_bo holds a new valid byte
//  rx_data_bo       out  8  last correctly received byte
//  rx_err_frame_o   out  1  one-cycle strobe: stop bit sampled low
// BEHAVIOUR
//  Reset (async, applies mid-frame as well):
//   - rx_done_tick_o=0, rx_err_frame_o=0, rx_data_bo=8'h00
//   - synchroniser FFs=1, state=IDLE, all counters=0
//  Sync: rx_i passes through a 2-FF synchroniser (rx_s); all logic below uses rx_s only.
//  Baud divider: count 0..DIV-1; samp_tick asserts when count==DIV-1.
//   - Divider is forced to 0 on the IDLE->START transition, aligning sampling to the start edge.
//  Bit timing:
//   - Sample counter sc runs 0..OVERSAMPLE-1, advancing on samp_tick.
//   - rx_s is captured at sc = H-1, H, H+1, where H = OVERSAMPLE/2.
//   - bit value = majority of the three samples.
//  States:
//   - IDLE: rx_s==0 -> START, sc=0.
//   - START: at sc==H+1, majority 1 -> IDLE (glitch, no output); else continue.
//     At sc==OVERSAMPLE-1 -> DATA, bit index=0.
//   - DATA: at sc==H+1, shift_reg <= {bit, shift_reg[7:1]}.
//     At sc==OVERSAMPLE-1: index==7 -> STOP, else index+1.
//   - STOP: evaluated at sc==H+1 (mid-stop, allows back-to-back frames).
//     - Majority 1: next cycle rx_data_bo<=shift_reg, rx_done_tick_o=1 for 1 cycle, -> IDLE.
//     - Majority 0: rx_err_frame_o=1 for 1 cycle, rx_data_bo unchanged, -> BREAK.
//   - BREAK: wait for rx_s==1, then -> IDLE (a held-low line never retriggers START).
//  Strobes:
//   - rx_done_tick_o and rx_err_frame_o are mutually exclusive and never high 2 cycles in a row.
//   - rx_data_bo changes only with rx_done_tick_o.
//  Latency: done tick fires (H+1)*DIV + 3 +/-1 clk after the stop bit's start edge on rx_i.
//  Tolerance: correct reception for transmitter baud error within +/-3%.
//  No flow control: the consumer must take rx_data_bo on the strobe cycle.
// TESTING (sim: CLK_FREQ_HZ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
//  1. Drive 8'hA5 8N1 -> exactly one rx_done_tick_o, rx_data_bo=8'hA5, rx_err_frame_o never high.
//  2. Back-to-back 8'h55,8'h5A,8'h00 (single stop bits) -> three ticks, data 55,5A,00 in order.
//  3. 30-clk low glitch on idle line -> no strobes, FSM back in IDLE, next byte 8'h81 received ok.
//  4. 8'h3C with stop bit low for 2 bit times, then high
//     -> one rx_err_frame_o, no done tick, rx_data_bo unchanged; following 8'h7E received ok.
//  5. 10-clk inversion centred on sample H of data bit 3 of 8'h0F -> majority keeps 8'h0F.
//  6. reset_i pulse mid-bit 4 of a byte -> outputs 0 immediately, no strobe; next 8'hC3 received ok.
//  7. 8'hA5 sent at BAUD_RATE*1.03 and BAUD_RATE*0.97 -> received correctly in both cases.

Source files
------------

// File: rtl/udm_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, oversampled bit timing with a 3-sample
// majority vote, one-cycle done/framing-error strobes for the UDM controller.
module udm_uart_rx #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic       rx_done_tick_o,
   output logic [7:0] rx_data_bo,
   output logic       rx_err_frame_o
);

   localparam int DIV   = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W = $clog2(DIV);
   localparam int SC_W  = $clog2(OVERSAMPLE);
   localparam int H     = OVERSAMPLE / 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
   localparam logic [SC_W-1:0]  SC_S0    = SC_W'(H - 2);
   localparam logic [SC_W-1:0]  SC_S1    = SC_W'(H - 1);
   localparam logic [SC_W-1:0]  SC_EVAL  = SC_W'(H);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic [2:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       samp_q, samp_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic samp_tick, eval, bit_end, maj;

   always_comb begin
      rx_meta_d = rx_i;
      rx_s_d    = rx_meta_q;

      samp_tick = (div_q == DIV_LAST);
      // Samples land on the ticks that move sc into H-1, H, H+1; the third
      // sample is the live rx_s on the H+1 tick, so the vote is decided there.
      eval    = samp_tick && (sc_q == SC_EVAL);
      bit_end = samp_tick && (sc_q == SC_LAST);
      maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

      div_d = samp_tick ? '0 : div_q + DIV_W'(1);
      sc_d  = sc_q;
      if (samp_tick)
         sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);

      samp_d = samp_q;
      if (samp_tick && (sc_q == SC_S0))
         samp_d[0] = rx_s_q;
      if (samp_tick && (sc_q == SC_S1))
         samp_d[1] = rx_s_q;

      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sc_d = '0;
            if (!rx_s_q) begin
               // Restart the divider so sampling is phased to the start edge.
               state_d = ST_START;
               div_d   = '0;
            end
         end
         ST_START: begin
            if (eval && maj) begin
               state_d = ST_IDLE;
               sc_d    = '0;
            end else if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (eval)
               shift_d = {maj, shift_q[7:1]};
            if (bit_end) begin
               if (bit_q == 3'd7)
                  state_d = ST_STOP;
               else
                  bit_d = bit_q + 3'd1;
            end
         end
         ST_STOP: begin
            // Decide at mid-stop so a following start edge is never missed.
            if (eval) begin
               sc_d = '0;
               if (maj) begin
                  data_d  = shift_q;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            sc_d = '0;
            if (rx_s_q)
               state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         div_q     <= '0;
         sc_q      <= '0;
         bit_q     <= '0;
         samp_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         div_q     <= div_d;
         sc_q      <= sc_d;
         bit_q     <= bit_d;
         samp_q    <= samp_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign rx_done_tick_o = done_q;
   assign rx_err_frame_o = err_q;
   assign rx_data_bo     = data_q;

endmodule

// File: tb/tb_udm_uart_rx.sv
// Self-checking bench for udm_uart_rx: frames are generated as line waveforms and
// the received stream is compared against a byte-level model of what was sent.
module tb_udm_uart_rx;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 10000;
   localparam int OS     = 16;
   localparam int BITCLK = 160;
   localparam int NOINV  = -100;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       rx_i;
   logic       rx_done_tick_o;
   logic [7:0] rx_data_bo;
   logic       rx_err_frame_o;

   always #5 clk = ~clk;

   udm_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .rx_i          (rx_i),
      .rx_done_tick_o(rx_done_tick_o),
      .rx_data_bo    (rx_data_bo),
      .rx_err_frame_o(rx_err_frame_o)
   );

   int         chk_cnt  = 0;
   int         pass_cnt = 0;
   int         err_cnt  = 0;
   int         viol_cnt = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         exp_err  = 0;
   logic [7:0] last_good = 8'h00;
   logic       prev_done = 1'b0;
   logic       prev_err  = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Output monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      if (reset_i) begin
         prev_done = 1'b0;
         prev_err  = 1'b0;
         prev_data = rx_data_bo;
      end else begin
         if (rx_done_tick_o) got_q.push_back(rx_data_bo);
         if (rx_err_frame_o) err_cnt++;
         if ((rx_done_tick_o && rx_err_frame_o) || (rx_done_tick_o && prev_done) ||
             (rx_err_frame_o && prev_err) || ((rx_data_bo !== prev_data) && !rx_done_tick_o))
            viol_cnt++;
         prev_done = rx_done_tick_o;
         prev_err  = rx_err_frame_o;
         prev_data = rx_data_bo;
      end
   end

   // Reference model: a frame with a good stop bit delivers its byte, a low stop bit is an error.
   task automatic model_frame(input logic [7:0] b, input bit bad_stop);
      if (bad_stop) exp_err++;
      else begin
         exp_q.push_back(b);
         last_good = b;
      end
   endtask

   task automatic start_scenario();
      got_q.delete();
      exp_q.delete();
      exp_err = 0;
      err_cnt = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bitclk, input bit bad_stop,
                             input int gap, input int inv_bit, input int inv_from, input int inv_len);
      logic lvl;
      int   len;
      for (int i = 0; i < 10; i++) begin
         len = (i == 9 && bad_stop) ? 2 * bitclk : bitclk;
         for (int c = 0; c < len; c++) begin
            lvl = (i == 0) ? 1'b0 : (i == 9) ? !bad_stop : b[i-1];
            if (i == inv_bit + 1 && c >= inv_from && c < inv_from + inv_len) lvl = !lvl;
            @(negedge clk) rx_i = lvl;
         end
      end
      repeat (gap + (bad_stop ? bitclk : 0)) @(negedge clk) rx_i = 1'b1;
   endtask

   task automatic test_reset();
      rx_i = 1'b1;
      reset_i = 1'b1;
      repeat (4) @(negedge clk);
      chk_cnt++; if (rx_done_tick_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", rx_done_tick_o); else pass_cnt++;
      chk_cnt++; if (rx_err_frame_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", rx_err_frame_o); else pass_cnt++;
      chk_cnt++; if (rx_data_bo !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data_bo); else pass_cnt++;
      reset_i = 1'b0;
      repeat (BITCLK) @(negedge clk);
      chk_cnt++; if (got_q.size() != 0 || err_cnt != 0) $display("FAIL idle_quiet ticks=%0d errs=%0d exp=0/0", got_q.size(), err_cnt); else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_single();
      start_scenario();
      send_frame(8'hA5, BITCLK, 1'b0, 40, NOINV, 0, 0);
      model_frame(8'hA5, 1'b0);
      chk_cnt++; if (got_q.size() != 1) $display("FAIL single_count got=%0d exp=1", got_q.size()); else pass_cnt++;
      chk_cnt++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL single_data got=%h exp=%h", got_q[0], exp_q[0]); else pass_cnt++;
      chk_cnt++; if (err_cnt != exp_err) $display("FAIL single_err got=%0d exp=%0d", err_cnt, exp_err); else pass_cnt++;
      $display("test_single byte=A5 ticks=%0d", got_q.size());
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3] = '{8'h55, 8'h5A, 8'h00};
      start_scenario();
      for (int i = 0; i < 3; i++) begin
         send_frame(bytes[i], BITCLK, 1'b0, (i == 2) ? 40 : 0, NOINV, 0, 0);
         model_frame(bytes[i], 1'b0);
      end
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         chk_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      $display("test_back_to_back ticks=%0d", got_q.size());
   endtask

   task automatic test_glitch();
      start_scenario();
      repeat (30) @(negedge clk) rx_i = 1'b0;
      repeat (400) @(negedge clk) rx_i = 1'b1;
      chk_cnt++; if (got_q.size() != 0 || err_cnt != 0) $display("FAIL glitch_quiet ticks=%0d errs=%0d exp=0/0", got_q.size(), err_cnt); else pass_cnt++;
      send_frame(8'h81, BITCLK, 1'b0, 40, NOINV, 0, 0);
      model_frame(8'h81, 1'b0);
      chk_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL glitch_next ticks=%0d exp=1 byte=%h", got_q.size(), exp_q[0]); else pass_cnt++;
      $display("test_glitch ticks=%0d", got_q.size());
   endtask

   task automatic test_frame_error();
      logic [7:0] held;
      start_scenario();
      held = last_good;
      send_frame(8'h3C, BITCLK, 1'b1, 40, NOINV, 0, 0);
      model_frame(8'h3C, 1'b1);
      chk_cnt++; if (err_cnt != exp_err) $display("FAIL ferr_count got=%0d exp=%0d", err_cnt, exp_err); else pass_cnt++;
      chk_cnt++; if (got_q.size() != 0) $display("FAIL ferr_notick got=%0d exp=0", got_q.size()); else pass_cnt++;
      chk_cnt++; if (rx_data_bo !== held) $display("FAIL ferr_data_held got=%h exp=%h", rx_data_bo, held); else pass_cnt++;
      send_frame(8'h7E, BITCLK, 1'b0, 40, NOINV, 0, 0);
      model_frame(8'h7E, 1'b0);
      chk_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL ferr_next ticks=%0d exp=1 byte=%h", got_q.size(), exp_q[0]); else pass_cnt++;
      $display("test_frame_error errs=%0d", err_cnt);
   endtask

   task automatic test_majority();
      start_scenario();
      // Line samples fall about 70/80/90 clk into each bit; invert around the 80 clk one.
      send_frame(8'h0F, BITCLK, 1'b0, 40, 3, 75, 10);
      model_frame(8'h0F, 1'b0);
      chk_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL majority ticks=%0d exp=1 byte=%h", got_q.size(), exp_q[0]); else pass_cnt++;
      $display("test_majority ticks=%0d", got_q.size());
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      logic [9:0] frame;
      start_scenario();
      b = 8'($urandom_range(0, 255));
      frame = {1'b1, b, 1'b0};
      for (int n = 0; n < 5 * BITCLK + 80; n++) @(negedge clk) rx_i = frame[n / BITCLK];
      #2 reset_i = 1'b1;
      #1;
      chk_cnt++; if (rx_data_bo !== 8'h00) $display("FAIL rst_mid_data got=%h exp=00", rx_data_bo); else pass_cnt++;
      chk_cnt++; if (rx_done_tick_o !== 1'b0 || rx_err_frame_o !== 1'b0) $display("FAIL rst_mid_strobes got=%b%b exp=00", rx_done_tick_o, rx_err_frame_o); else pass_cnt++;
      rx_i = 1'b1;
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      repeat (2 * BITCLK) @(negedge clk);
      chk_cnt++; if (got_q.size() != 0 || err_cnt != 0) $display("FAIL rst_mid_quiet ticks=%0d errs=%0d exp=0/0", got_q.size(), err_cnt); else pass_cnt++;
      send_frame(8'hC3, BITCLK, 1'b0, 40, NOINV, 0, 0);
      model_frame(8'hC3, 1'b0);
      chk_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL rst_mid_next ticks=%0d exp=1 byte=%h", got_q.size(), exp_q[0]); else pass_cnt++;
      $display("test_reset_mid_frame aborted=%h", b);
   endtask

   task automatic test_baud_tolerance();
      int rates [2] = '{155, 165};
      for (int r = 0; r < 2; r++) begin
         start_scenario();
         send_frame(8'hA5, rates[r], 1'b0, 60, NOINV, 0, 0);
         model_frame(8'hA5, 1'b0);
         chk_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err_cnt != 0)
            $display("FAIL baud_%0d ticks=%0d errs=%0d exp=1/0 byte=%h", rates[r], got_q.size(), err_cnt, exp_q[0]);
         else pass_cnt++;
         $display("test_baud_tolerance bitclk=%0d ticks=%0d", rates[r], got_q.size());
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         bad;
      int         bclk;
      start_scenario();
      for (int i = 0; i < 8; i++) begin
         b    = 8'($urandom_range(0, 255));
         bad  = ($urandom_range(0, 4) == 0);
         bclk = $urandom_range(155, 165);
         send_frame(b, bclk, bad, $urandom_range(0, 200), NOINV, 0, 0);
         model_frame(b, bad);
         $display("test_random frame=%0d byte=%h bitclk=%0d bad_stop=%0d", i, b, bclk, bad);
      end
      repeat (40) @(negedge clk);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
      chk_cnt++; if (err_cnt != exp_err) $display("FAIL rand_err got=%0d exp=%0d", err_cnt, exp_err); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (rx_data_bo !== last_good) $display("FAIL rand_last got=%h exp=%h", rx_data_bo, last_good); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_majority();
      test_reset_mid_frame();
      test_baud_tolerance();
      test_random();
      chk_cnt++; if (viol_cnt != 0) $display("FAIL strobe_rules got=%0d violations exp=0", viol_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
